glb_stream_reader: RTL and testbench
====================================

# glb_stream_reader

Read-side sequencer for one global buffer (iact, psum or weight GLB). It walks a block of addresses, issues `read_req`/`r_addr` to the buffer, and captures the returned `r_data` one cycle later. Captured words go into a small credit-controlled FIFO and are presented downstream on a valid/ready stream. It sits between the layer controller and the PE-array input or off-chip drain path, and is the initiator for the GLB read port.

## Interface
Parameters:
- `DATA_BITWIDTH`, 16, GLB word width
- `ADDR_BITWIDTH`, 10, GLB address width
- `FIFO_DEPTH`, 4, capture FIFO entries; power of two, at least 2

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  launch a transfer; sampled only in IDLE
- `base_addr`  in  ADDR_BITWIDTH  first address; sampled with `start`
- `length`  in  ADDR_BITWIDTH+1  word count, 0 to 2^ADDR_BITWIDTH; sampled with `start`
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse when the transfer completes
- `read_req`  out  1  GLB read request
- `r_addr`  out  ADDR_BITWIDTH  GLB read address
- `r_data`  in  DATA_BITWIDTH  GLB read data, valid the cycle after `read_req`
- `out_data`  out  DATA_BITWIDTH  stream data
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready

## Operation
- FSM states:
  - IDLE: `start`=1 with `length`≠0 goes to ISSUE. `start`=1 with `length`=0 goes to DONE.
  - ISSUE: one read per cycle while `count + inflight < FIFO_DEPTH`. After the last read is issued, go to DRAIN.
  - DRAIN: wait until `inflight`=0 and the FIFO is empty (last word handshaked), then go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `base_addr` and `length` are latched only on an accepted start.
- Address advances by 1 per issued read, modulo 2^ADDR_BITWIDTH. Wrap from 1023 to 0 is legal.
- `inflight` is 1 bit because read latency is fixed at 1. On the cycle after `read_req`=1, `r_data` is written into the FIFO unconditionally. The credit check guarantees space.
- A stream handshake happens when `out_valid && out_ready`. A simultaneous push and pop leaves `count` unchanged.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- The remaining-word counter is ADDR_BITWIDTH+1 bits, so `length`=2^ADDR_BITWIDTH reads every address exactly once.
- Reset mid-transfer: all state returns to IDLE immediately, the FIFO is emptied, and no `done` is generated. A `r_data` return that was in flight is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `read_req`=0, `r_addr`=0, `out_valid`=0, `out_data`=0.
- `start` is sampled at edge 0.
  - Cycle 1: `busy`=1, `read_req`=1, `r_addr`=`base_addr`.
  - Edge 2: the word is captured.
  - Cycle 2: `out_valid`=1 at the earliest.
- With `out_ready` held high, throughput is 1 word/cycle with no bubbles after the first.
- For N words under continuous ready, the last handshake is in cycle N+1, DONE (`done`=1) is in cycle N+2, and `busy` falls in cycle N+3.
- `busy` is 1 in ISSUE, DRAIN and DONE.
- For `length`=0, `done`=1 in cycle 1 and `read_req` never asserts.
- Backpressure: `read_req` deasserts within one cycle once `count + inflight` reaches FIFO_DEPTH. No data is lost or duplicated.

## Configuration
- `GLB_RD_STRIDE_EN` defined:
  - Adds port `stride` (in, ADDR_BITWIDTH), latched with `start`.
  - The address advances by `stride` per read, modulo 2^ADDR_BITWIDTH.
  - `stride`=0 rereads `base_addr` `length` times.
- `GLB_RD_STRIDE_EN` undefined: no `stride` port; increment is fixed at 1.

## Test plan
- Reset then idle: all outputs 0; `start` with `length`=0 gives `done` in cycle 1, no `read_req`, `out_valid` stays 0.
- `base_addr`=5, `length`=8, `out_ready`=1, GLB preloaded with data=addr: outputs 5..12 in order on cycles 2..9; `done` in cycle 10.
- Same transfer with `out_ready` toggling 1,0,0,1 repeating: all 8 words delivered once, in order, with `out_data` stable during stalls. `read_req` is never high when `count + inflight` equals FIFO_DEPTH.
- `base_addr`=1020, `length`=8: `r_addr` sequence is 1020..1023, 0..3. `length`=1024 from 0 reads every address exactly once.
- Assert `reset` during ISSUE after 3 words: outputs clear immediately and no `done` is generated. A following transfer behaves normally.
- Define `GLB_RD_STRIDE_EN`, `base_addr`=2, `stride`=3, `length`=4: reads addresses 2, 5, 8, 11 in that order. A `start` pulsed mid-transfer is ignored.

Source files
------------

// File: rtl/glb_stream_reader.sv
// Purpose: read-side sequencer for one GLB; walks base_addr for length words and streams them out.
// Latency: start edge -> read_req next cycle; each word is captured on the edge closing its read and is valid the cycle after.
// Backpressure: out_ready stalls the FIFO head; credits (count + inflight) gate read_req so the FIFO never overflows.
// Build option: define GLB_RD_STRIDE_EN to add a per-transfer address stride port (default build steps by 1).

// Small capture FIFO: power-of-two depth, registered head, occupancy count exported for credit checks.
module glb_rd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign pop      = head_vld && pop_rdy;

  // Next-state for storage, pointers and occupancy; push and pop together leave the count alone.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_vld, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

module glb_stream_reader #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [ADDR_BITWIDTH:0]   length,
`ifdef GLB_RD_STRIDE_EN
  input  logic [ADDR_BITWIDTH-1:0] stride,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     read_req,
  output logic [ADDR_BITWIDTH-1:0] r_addr,
  input  logic [DATA_BITWIDTH-1:0] r_data,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]            DEPTH_CREDITS = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]          CNT_ONE       = CW'(1);
  localparam logic [ADDR_BITWIDTH:0] REM_ONE       = (ADDR_BITWIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_BITWIDTH-1:0]   r_addr_q, r_addr_d;
  logic [ADDR_BITWIDTH:0]     remain_q, remain_d;
  logic                       read_req_q, read_req_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [ADDR_BITWIDTH-1:0]   step_new;
  logic [ADDR_BITWIDTH-1:0]   step_cur;
  logic [CW-1:0]              fifo_count;
  logic [CW:0]                credit_used;
  logic                       inflight;
  logic                       credit_ok;
  logic                       pop;
  logic                       drain_clear;

`ifdef GLB_RD_STRIDE_EN
  logic [ADDR_BITWIDTH-1:0]   step_q, step_d;

  // Stride is captured only when a start is accepted and held for the whole transfer.
  always_comb begin
    step_d = step_q;
    if (state_q == S_IDLE && start) begin
      step_d = stride;
    end
  end

  // Stride register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_new = stride;
  assign step_cur = step_q;
`else
  assign step_new = ADDR_BITWIDTH'(1);
  assign step_cur = ADDR_BITWIDTH'(1);
`endif

  // A read on the bus this cycle returns its word at the closing edge, so it already owns a FIFO slot.
  assign inflight    = read_req_q;
  assign pop         = out_valid && out_ready;
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign credit_ok   = (credit_used < DEPTH_CREDITS);
  // Finished once nothing is returning and the FIFO empties at this edge (last word handshaking now).
  assign drain_clear = !inflight &&
                       ((fifo_count == '0) || ((fifo_count == CNT_ONE) && pop));

  // Sequencer next-state: address walk, remaining-read count and the registered outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    r_addr_d   = r_addr_q;
    remain_d   = remain_q;
    read_req_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d    = S_ISSUE;
            read_req_d = 1'b1;
            r_addr_d   = base_addr;
            addr_d     = base_addr + step_new;
            remain_d   = length - REM_ONE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (remain_q == '0) begin
          state_d = S_DRAIN;
        end else if (credit_ok) begin
          read_req_d = 1'b1;
          r_addr_d   = addr_q;
          addr_d     = addr_q + step_cur;
          remain_d   = remain_q - REM_ONE;
        end
      end
      S_DRAIN: begin
        if (drain_clear) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Sequencer state and registered outputs; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      r_addr_q   <= '0;
      remain_q   <= '0;
      read_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      r_addr_q   <= r_addr_d;
      remain_q   <= remain_d;
      read_req_q <= read_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign read_req = read_req_q;
  assign r_addr   = r_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Returned words are written unconditionally; the credit check above guarantees room.
  glb_rd_fifo #(
    .W     (DATA_BITWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (inflight),
    .push_dat (r_data),
    .pop_rdy  (out_ready),
    .head_vld (out_valid),
    .head_dat (out_data),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_glb_stream_reader.sv
module tb_glb_stream_reader;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
`ifdef GLB_RD_STRIDE_EN
  logic [AW-1:0] stride;
`endif
  logic          busy, done, read_req, out_valid, out_ready;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data, out_data;
  logic [DW-1:0] junk = '0;

  // Buffer contents seen by the DUT; also the reference for every expected word.
  logic [DW-1:0] glb [1024];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Buffer model: the requested word is on r_data while read_req is up; noise otherwise.
  always @(negedge clk) junk <= DW'($urandom);
  assign r_data = read_req ? glb[r_addr] : junk;

  glb_stream_reader #(
    .DATA_BITWIDTH (DW),
    .ADDR_BITWIDTH (AW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef GLB_RD_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .read_req  (read_req),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_glb(input bit rnd);
    for (int i = 0; i < 1024; i++) begin
      glb[i] = rnd ? DW'($urandom) : DW'(i);
    end
  endtask

  // One transfer. Expected word i is glb[(base + i*inc) mod 1024].
  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
  // poke: pulse a bogus start in cycle 3, which must be ignored.
  task automatic run_xfer(input int base, input int len, input int inc, input int mode, input bit poke);
    int c        = 1;
    int rd_n     = 0;
    int hs_n     = 0;
    int first_v  = -1;
    int done_c   = -1;
    int busy_bad = 0;
    int budget   = len * 4 + 20;
    int occ;
    bit got_done   = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    length    = (AW+1)'(len);
`ifdef GLB_RD_STRIDE_EN
    stride    = AW'(inc);
`endif
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!got_done && c <= budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 4) == 1) || ((c % 4) == 0);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (!busy) busy_bad++;
      if (read_req) begin
        occ = rd_n - hs_n;
        chk("credit", occ < DEPTH, 1);
        chk("r_addr", r_addr, (base + rd_n * inc) % 1024);
        rd_n++;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_dat);
      end
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        chk("word_expected", hs_n < len, 1);
        if (out_ready) begin
          chk("out_data", out_data, glb[(base + hs_n * inc) % 1024]);
          hs_n++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      if (done) begin
        got_done = 1'b1;
        done_c   = c;
        chk("words_at_done", hs_n, len);
        chk("reads_at_done", rd_n, len);
      end else begin
        if (poke && c == 3) begin
          start     = 1'b1;
          base_addr = AW'($urandom);
          length    = (AW+1)'($urandom_range(1, 50));
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    if (mode == 0) begin
      chk("first_valid_cycle", first_v, (len > 0) ? 2 : -1);
      chk("done_cycle", done_c, (len > 0) ? len + 2 : 1);
    end
    chk("busy_during", busy_bad, 0);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_fall", busy, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int seen;
    int bad;
    int rlen;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b0;
`ifdef GLB_RD_STRIDE_EN
    stride    = '0;
`endif
    fill_glb(1'b0);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read_req", read_req, 0);
    chk("rst_r_addr", r_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_read_req", read_req, 0);

    // Zero-length, directed, stalled and wrapping transfers on data = address.
    run_xfer(7, 0, 1, 0, 1'b0);
    run_xfer(5, 8, 1, 0, 1'b0);
    run_xfer(5, 8, 1, 1, 1'b0);
    run_xfer(1020, 8, 1, 0, 1'b0);

    // Full address space once, random contents.
    fill_glb(1'b1);
    run_xfer(0, 1024, 1, 0, 1'b0);

    // Reset after three reads have been issued.
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'($urandom);
    length    = (AW+1)'(20);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int k = 0; k < 10 && seen < 3; k++) begin
      if (read_req) seen++;
      if (seen < 3) @(negedge clk);
    end
    chk("reads_before_reset", seen, 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_read_req", read_req, 0);
    chk("mid_rst_r_addr", r_addr, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b0;
    bad   = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || out_valid || read_req) bad++;
    end
    chk("quiet_after_reset", bad, 0);
    run_xfer(int'($urandom_range(0, 1023)), 12, 1, 0, 1'b1);

`ifdef GLB_RD_STRIDE_EN
    run_xfer(2, 4, 3, 0, 1'b1);
    run_xfer(100, 6, 0, 2, 1'b0);
`endif

    // Randomized transfers with random or patterned backpressure.
    for (int t = 0; t < 14; t++) begin
      int inc;
      rlen = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
`ifdef GLB_RD_STRIDE_EN
      inc = int'($urandom_range(0, 1023));
`else
      inc = 1;
`endif
      if (t % 5 == 0) fill_glb(1'b1);
      run_xfer(int'($urandom_range(0, 1023)), rlen, inc, (t % 3 == 0) ? 1 : 2, rlen >= 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
